// File: rtl/ta_pkg.sv
// Shared definitions for the ADC capture buffer: FSM encoding and default widths.
package ta_pkg;

  localparam int ADC0_1_DEFAULT  = 56;
  localparam int LEN_W_DEFAULT   = 16;
  localparam int FIFO_AW_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } cap_state_t;

  // Where a capture goes once its skip phase is over (or absent): skip first,
  // then store, and straight to DONE when there is nothing left to do.
  function automatic cap_state_t entry_state(input logic skip_nz, input logic len_nz);
    if (skip_nz) begin
      return ST_SKIP;
    end else if (len_nz) begin
      return ST_CAPT;
    end else begin
      return ST_DONE;
    end
  endfunction

endpackage

// File: rtl/ta_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Storage is a plain array so it
// maps onto block RAM; the head word sits in a register that is either loaded
// from RAM or, when the word being written is the next head, straight from
// the write data.
module ta_sync_fifo #(
  parameter int DW = 56,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [DW-1:0] head_q;
  logic          push;
  logic          pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign pop        = rd_en & ~empty;
  assign push       = wr_en & (~full | pop);
  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign rd_data    = head_q;

  // RAM write port; no reset so the array stays a block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head register: bypass the write data when it lands where the head will be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (flush) begin
      head_q <= '0;
    end else if (push || pop) begin
      head_q <= (push && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ta_cap_buf.sv
// Capture buffer behind the ADC merge stage: drops a programmable number of
// leading merged words, stores the following ones in a FIFO and streams them
// out over valid/ready, reporting completion and FIFO overflow.
module ta_cap_buf
  import ta_pkg::*;
#(
  parameter int ADC0_1  = ADC0_1_DEFAULT,
  parameter int FIFO_AW = FIFO_AW_DEFAULT,
  parameter int LEN_W   = LEN_W_DEFAULT
) (
  input  logic              clk62,
  input  logic              rst,
  input  logic              mem_reset,
  input  logic [ADC0_1-1:0] merge_data,
  input  logic              mereg_datv,
  input  logic              cap_start,
  input  logic [LEN_W-1:0]  cap_skip,
  input  logic [LEN_W-1:0]  cap_len,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_ovf,
  output logic [ADC0_1-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [FIFO_AW:0]  fifo_cnt
);

  cap_state_t       state_q;
  cap_state_t       state_d;
  logic [LEN_W-1:0] skip_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic             start_ok;
  logic             word_capt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_full_eff;
  logic             fifo_wr;

  // A start is only honoured when no capture is in flight.
  assign start_ok = cap_start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // A concurrent pop frees a slot, so a full FIFO still takes the word then.
  assign word_capt     = (state_q == ST_CAPT) & mereg_datv;
  assign fifo_full_eff = fifo_full & ~(rd_valid & rd_ready);
  assign fifo_wr       = word_capt & ~fifo_full_eff;
  assign rd_valid      = ~fifo_empty;

  ta_sync_fifo #(
    .DW (ADC0_1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk62),
    .rst_n   (rst),
    .flush   (mem_reset),
    .wr_en   (fifo_wr),
    .wr_data (merge_data),
    .rd_en   (rd_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // State register.
  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; mem_reset overrides everything, including cap_start.
  always_comb begin
    state_d = state_q;
    if (mem_reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cap_start) begin
            state_d = entry_state(cap_skip != '0, cap_len != '0);
          end
        end
        ST_SKIP: begin
          if (mereg_datv && (skip_cnt == LEN_W'(1))) begin
            state_d = entry_state(1'b0, len_cnt != '0);
          end
        end
        ST_CAPT: begin
          if (mereg_datv && (len_cnt == LEN_W'(1))) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags decoded from the registered state only.
  always_comb begin
    cap_busy = 1'b0;
    cap_done = 1'b0;
    case (state_q)
      ST_SKIP, ST_CAPT: cap_busy = 1'b1;
      ST_DONE:          cap_done = 1'b1;
      default: begin
        cap_busy = 1'b0;
        cap_done = 1'b0;
      end
    endcase
  end

  // Skip/length counters: loaded at start, counted down by valid words; the
  // length count also runs for dropped words so the capture window keeps its duration.
  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) begin
      skip_cnt <= '0;
      len_cnt  <= '0;
    end else if (mem_reset) begin
      skip_cnt <= '0;
      len_cnt  <= '0;
    end else if (start_ok) begin
      skip_cnt <= cap_skip;
      len_cnt  <= cap_len;
    end else if (mereg_datv) begin
      if (state_q == ST_SKIP) begin
        skip_cnt <= skip_cnt - 1'b1;
      end
      if (state_q == ST_CAPT) begin
        len_cnt <= len_cnt - 1'b1;
      end
    end
  end

  // Sticky overflow: a capture word found no room in the FIFO.
  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) begin
      cap_ovf <= 1'b0;
    end else if (mem_reset) begin
      cap_ovf <= 1'b0;
    end else if (word_capt && fifo_full_eff) begin
      cap_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/ta_cap_buf.md
Name: ta_cap_buf

Overview:
- Capture buffer directly downstream of the ADC clock/merge stage, in the clk62 domain.
- Consumes merged 4-sample ADC words (merge_data / mereg_datv) and discards a programmable number of leading words.
- Stores a programmable number of following words in an on-chip FIFO.
- Presents the stored words to the readout side over a valid/ready stream, and flags completion and overflow.

Parameters:
- ADC0_1, 56, width of one merged data word (4 x 14-bit samples).
- FIFO_AW, 10, FIFO address width; depth = 2^FIFO_AW words.
- LEN_W, 16, width of the skip and length counters.

Ports:
- clk62  input  1  single clock for the whole block; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- mem_reset  input  1  synchronous flush: clears the FIFO, flags and FSM; held-high acts as a sustained flush.
- merge_data  input  ADC0_1  merged ADC word.
- mereg_datv  input  1  merge_data valid, one cycle per word.
- cap_start  input  1  single-cycle start pulse, already synchronous to clk62.
- cap_skip  input  LEN_W  number of valid words to discard after start.
- cap_len  input  LEN_W  number of valid words to store; 0 = no store.
- cap_busy  output  1  high in SKIP or CAPT.
- cap_done  output  1  high in DONE; cleared by next cap_start or mem_reset.
- cap_ovf  output  1  sticky: a word arrived in CAPT while the FIFO was full.
- rd_data  output  ADC0_1  FIFO head word.
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  consumer accepts rd_data when rd_valid & rd_ready.
- fifo_cnt  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async):
  - FSM = IDLE; counters = 0; FIFO pointers = 0.
  - cap_busy=0, cap_done=0, cap_ovf=0, rd_valid=0, fifo_cnt=0, rd_data=0.
- cap_skip and cap_len are sampled into internal registers on the cap_start cycle; later changes are ignored.
- FSM states:
  - IDLE: on cap_start go to SKIP if skip>0, else CAPT if len>0, else DONE.
  - SKIP: each mereg_datv decrements skip_cnt. On the valid word that takes skip_cnt 1->0, go to CAPT (len>0) or DONE (len=0). That word is discarded.
  - CAPT: each mereg_datv writes merge_data to the FIFO and decrements len_cnt. On the word that takes len_cnt 1->0, go to DONE. That word is written.
  - DONE: cap_done=1. On cap_start, re-sample and branch exactly as from IDLE.
- cap_start while in SKIP or CAPT is ignored; the current capture completes.
- FIFO write:
  - Write enable = (state==CAPT) & mereg_datv & !full.
  - If full at that point: the word is dropped, cap_ovf set, len_cnt still decrements so capture length in time is preserved.
  - cap_ovf clears only on mem_reset or rst.
- FIFO read:
  - First-word-fall-through: rd_data is valid in the same cycle rd_valid is high.
  - A pop occurs when rd_valid & rd_ready.
  - Write-to-rd_valid latency: 1 cycle (word written at edge N shows rd_valid=1 after edge N).
  - Simultaneous push and pop: fifo_cnt unchanged. When full, a push with a simultaneous pop is accepted (full is evaluated after the pop).
  - Empty with rd_ready=1: no pop, pointers unchanged.
  - Pointers wrap modulo 2^FIFO_AW; fifo_cnt spans 0..2^FIFO_AW.
- mem_reset:
  - Priority above all other inputs, including cap_start in the same cycle.
  - Next cycle: FSM=IDLE, FIFO empty, cap_done=0, cap_ovf=0.
  - Mid-capture it aborts the capture with no completion flag.
- Words outside SKIP/CAPT are ignored.
- cap_busy and cap_done are decoded from registered state (no combinational path from inputs).

Decomposition:
- Shared package (ta_pkg): FSM state encoding (IDLE, SKIP, CAPT, DONE) and default widths ADC0_1 and LEN_W.
- One sub-module: ta_sync_fifo.
  - Parameterised on data width and address width.
  - FWFT, provides full, empty and count.
  - Backed by inferred block RAM with a registered head (bypass on write to an empty FIFO).
- The top holds the FSM, counters and overflow flag.

Test Plan:
- Basic capture: skip=3, len=5, continuous mereg_datv with word values 1,2,3,...
  -> FIFO receives 4..8; cap_done rises the cycle after word 8; rd stream with rd_ready=1 yields 4,5,6,7,8.
- Gapped valid: mereg_datv every 4th cycle, skip=0, len=4
  -> exactly 4 words stored; cap_busy stays high until the 4th valid word; fifo_cnt=4.
- Overflow: FIFO_AW=3, len=12, rd_ready=0
  -> first 8 words stored, cap_ovf=1, cap_done after the 12th valid word; readout yields words 1..8.
- Full with concurrent pop: FIFO full, rd_ready=1 and push in the same cycle
  -> word accepted, fifo_cnt stays 8, no cap_ovf.
- Abort: mem_reset during CAPT after 2 words
  -> next cycle rd_valid=0, fifo_cnt=0, cap_busy=0, cap_done=0; a later cap_start runs normally.
- Edge cases:
  - skip=0, len=0 -> cap_done one cycle after cap_start, nothing stored.
  - rst low mid-capture -> all outputs 0 immediately (asynchronous).
